// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
//
// Walks through the channels enabled in chan_mask in ascending order. For each
// channel it selects the AMUX input, waits for the input to settle, fires a
// one-cycle ADC trigger and then waits a bounded time for the conversion
// result. Each result comes out as a one-cycle res_valid strobe, and the end of
// the scan is marked by a one-cycle scan_done strobe.
//
// Ports
//   PCLK          clock, all state changes on the rising edge
//   PRESETn       synchronous active-low reset
//   start         one-cycle pulse that starts a scan (ignored while busy)
//   abort         drops back to IDLE on the next edge, with no strobes
//   chan_mask     enabled channels (bit i = channel i), latched at start
//   settle_cycles AMUX settling delay in cycles, latched at start
//   amux_sel      channel select to the AMUX
//   adc_trigger   one-cycle conversion start
//   adc_done      one-cycle conversion complete, only looked at in WAIT
//   adc_data      conversion result, valid together with adc_done
//   res_valid     one-cycle result strobe
//   res_chan      channel of the most recent result
//   res_data      most recent result
//   busy          high whenever the sequencer is not in IDLE
//   scan_done     one-cycle end-of-scan strobe
//   timeout_err   sticky flag: some conversion in the scan never completed
// ---------------------------------------------------------------------------
module adc_scan_sequencer #(
   parameter int  NUM_CH    = 8,
   parameter int  RES_WIDTH = 12,
   parameter int  TIMEOUT   = 255,
   localparam int CW        = $clog2(NUM_CH)
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_CH-1:0]    chan_mask,
   input  logic [7:0]           settle_cycles,
   output logic [CW-1:0]        amux_sel,
   output logic                 adc_trigger,
   input  logic                 adc_done,
   input  logic [RES_WIDTH-1:0] adc_data,
   output logic                 res_valid,
   output logic [CW-1:0]        res_chan,
   output logic [RES_WIDTH-1:0] res_data,
   output logic                 busy,
   output logic                 scan_done,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_TRIG,
      S_WAIT,
      S_NEXT
   } state_t;

   state_t               state_q,       state_d;
   logic [NUM_CH-1:0]    mask_q,        mask_d;
   logic [7:0]           settle_q,      settle_d;
   logic [7:0]           cnt_q,         cnt_d;
   logic [CW-1:0]        amux_sel_q,    amux_sel_d;
   logic                 adc_trigger_q, adc_trigger_d;
   logic                 res_valid_q,   res_valid_d;
   logic [CW-1:0]        res_chan_q,    res_chan_d;
   logic [RES_WIDTH-1:0] res_data_q,    res_data_d;
   logic                 busy_q,        busy_d;
   logic                 scan_done_q,   scan_done_d;
   logic                 timeout_err_q, timeout_err_d;

   // Channel launch request shared by IDLE (first channel) and NEXT (later ones)
   logic                 launch;
   logic [NUM_CH-1:0]    launch_mask;
   logic [7:0]           launch_settle;
   // Current channel finished, either by a result or by a timeout
   logic                 finish_ch;
   logic [NUM_CH-1:0]    rem_mask;

   // Index of the lowest set bit; scanning high to low leaves the lowest last.
   function automatic logic [CW-1:0] lowest_set(input logic [NUM_CH-1:0] m);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) idx = CW'(i);
      end
      return idx;
   endfunction

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      settle_d      = settle_q;
      cnt_d         = cnt_q;
      amux_sel_d    = amux_sel_q;
      adc_trigger_d = 1'b0;
      res_valid_d   = 1'b0;
      res_chan_d    = res_chan_q;
      res_data_d    = res_data_q;
      scan_done_d   = 1'b0;
      timeout_err_d = timeout_err_q;
      launch        = 1'b0;
      launch_mask   = mask_q;
      launch_settle = settle_q;
      finish_ch     = 1'b0;
      rem_mask      = mask_q & ~(NUM_CH'(1) << amux_sel_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               timeout_err_d = 1'b0;
               if (chan_mask != '0) begin
                  mask_d        = chan_mask;
                  settle_d      = settle_cycles;
                  launch        = 1'b1;
                  launch_mask   = chan_mask;
                  launch_settle = settle_cycles;
               end else begin
                  // Empty scan: report completion without ever going busy
                  scan_done_d = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == 8'd0) begin
               state_d       = S_TRIG;
               adc_trigger_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_TRIG: begin
            state_d = S_WAIT;
            cnt_d   = 8'd1;          // cnt_q counts WAIT cycles starting at 1
         end
         S_WAIT: begin
            if (adc_done) begin
               res_data_d  = adc_data;
               res_chan_d  = amux_sel_q;
               res_valid_d = 1'b1;
               finish_ch   = 1'b1;
            end else if (cnt_q == 8'(TIMEOUT)) begin
               timeout_err_d = 1'b1;
               finish_ch     = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_NEXT: begin
            if (mask_q == '0) begin
               state_d = S_IDLE;
            end else begin
               launch = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // scan_done is raised on entry to NEXT so it lines up with the last
      // res_valid of the scan.
      if (finish_ch) begin
         state_d     = S_NEXT;
         mask_d      = rem_mask;
         scan_done_d = (rem_mask == '0);
      end

      if (launch) begin
         amux_sel_d = lowest_set(launch_mask);
         if (launch_settle == 8'd0) begin
            state_d       = S_TRIG;
            adc_trigger_d = 1'b1;
         end else begin
            state_d = S_SETTLE;
            cnt_d   = launch_settle - 8'd1;
         end
      end

      // Abort wins over everything, including a start in the same cycle: the
      // scan vanishes without strobes and the visible results are left alone.
      if (abort) begin
         state_d       = S_IDLE;
         mask_d        = mask_q;
         settle_d      = settle_q;
         cnt_d         = cnt_q;
         amux_sel_d    = amux_sel_q;
         adc_trigger_d = 1'b0;
         res_valid_d   = 1'b0;
         res_chan_d    = res_chan_q;
         res_data_d    = res_data_q;
         scan_done_d   = 1'b0;
         timeout_err_d = timeout_err_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q       <= S_IDLE;
         mask_q        <= '0;
         settle_q      <= '0;
         cnt_q         <= '0;
         amux_sel_q    <= '0;
         adc_trigger_q <= 1'b0;
         res_valid_q   <= 1'b0;
         res_chan_q    <= '0;
         res_data_q    <= '0;
         busy_q        <= 1'b0;
         scan_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         settle_q      <= settle_d;
         cnt_q         <= cnt_d;
         amux_sel_q    <= amux_sel_d;
         adc_trigger_q <= adc_trigger_d;
         res_valid_q   <= res_valid_d;
         res_chan_q    <= res_chan_d;
         res_data_q    <= res_data_d;
         busy_q        <= busy_d;
         scan_done_q   <= scan_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign amux_sel    = amux_sel_q;
   assign adc_trigger = adc_trigger_q;
   assign res_valid   = res_valid_q;
   assign res_chan    = res_chan_q;
   assign res_data    = res_data_q;
   assign busy        = busy_q;
   assign scan_done   = scan_done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for adc_scan_sequencer. Stimulus builds, per scan, the list of
// expected triggers, results and end-of-scan events (with the cycle each must
// appear in); an independent monitor pops and compares them whenever the DUT
// raises adc_trigger, res_valid or scan_done. An ADC model answers triggers.
// ---------------------------------------------------------------------------
module tb_adc_scan_sequencer;

   localparam int NUM_CH = 8;
   localparam int RES_W  = 12;
   localparam int TMO    = 255;
   localparam int CW     = 3;

   logic              PCLK = 1'b0;
   logic              PRESETn = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [NUM_CH-1:0] chan_mask = '0;
   logic [7:0]        settle_cycles = '0;
   logic [CW-1:0]     amux_sel;
   logic              adc_trigger;
   logic              adc_done = 1'b0;
   logic [RES_W-1:0]  adc_data = '0;
   logic              res_valid;
   logic [CW-1:0]     res_chan;
   logic [RES_W-1:0]  res_data;
   logic              busy;
   logic              scan_done;
   logic              timeout_err;

   adc_scan_sequencer #(
      .NUM_CH    (NUM_CH),
      .RES_WIDTH (RES_W),
      .TIMEOUT   (TMO)
   ) dut (
      .PCLK          (PCLK),
      .PRESETn       (PRESETn),
      .start         (start),
      .abort         (abort),
      .chan_mask     (chan_mask),
      .settle_cycles (settle_cycles),
      .amux_sel      (amux_sel),
      .adc_trigger   (adc_trigger),
      .adc_done      (adc_done),
      .adc_data      (adc_data),
      .res_valid     (res_valid),
      .res_chan      (res_chan),
      .res_data      (res_data),
      .busy          (busy),
      .scan_done     (scan_done),
      .timeout_err   (timeout_err)
   );

   always #5 PCLK = ~PCLK;

   typedef struct { int cyc; int chan; int data; } ev_t;
   typedef struct { int n; int d; } plan_t;

   ev_t   trig_q[$];
   ev_t   res_q[$];
   ev_t   done_q[$];
   plan_t plan_q[$];          // ADC answer per trigger: delay (0 = never), data
   int    dq[$];              // optional fixed conversion data

   int cyc     = 0;           // number of rising edges so far
   int n_cmp   = 0;
   int n_fail  = 0;
   int busy_lo = 1;
   int busy_hi = 0;
   bit mon_en  = 1'b0;
   int last_data = 0;
   int last_chan = 0;
   bit exp_te    = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge PCLK) cyc++;

   // Monitor: every strobe must match the next expected event, in its cycle
   always @(negedge PCLK) if (mon_en) begin
      ev_t e;
      chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (adc_trigger) begin
         chk("trig_expected", trig_q.size() != 0, 1);
         if (trig_q.size() != 0) begin
            e = trig_q.pop_front();
            chk("trig_cycle", cyc, e.cyc);
            chk("trig_amux_sel", amux_sel, e.chan);
         end
      end
      if (res_valid) begin
         chk("res_expected", res_q.size() != 0, 1);
         if (res_q.size() != 0) begin
            e = res_q.pop_front();
            chk("res_cycle", cyc, e.cyc);
            chk("res_chan", res_chan, e.chan);
            chk("res_data", res_data, e.data);
         end
      end
      if (scan_done) begin
         chk("done_expected", done_q.size() != 0, 1);
         if (done_q.size() != 0) begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // ADC model: answers each trigger after its planned delay, and now and then
   // emits a stray adc_done while the sequencer is idle.
   always begin
      plan_t p;
      @(negedge PCLK);
      adc_done = 1'b0;
      adc_data = RES_W'($urandom);
      if (adc_trigger === 1'b1) begin
         if (plan_q.size() != 0) begin
            p = plan_q.pop_front();
            if (p.n > 0) begin
               repeat (p.n) @(negedge PCLK);
               adc_done = 1'b1;
               adc_data = RES_W'(p.d);
            end
         end
      end else if (PRESETn && busy === 1'b0 && $urandom_range(0, 15) == 0) begin
         adc_done = 1'b1;
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_amux_sel"},    amux_sel,    0);
      chk({tag, "_adc_trigger"}, adc_trigger, 0);
      chk({tag, "_res_valid"},   res_valid,   0);
      chk({tag, "_res_chan"},    res_chan,    0);
      chk({tag, "_res_data"},    res_data,    0);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_scan_done"},   scan_done,   0);
      chk({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic chk_idle_state(input string tag);
      chk({tag, "_timeout_err"}, timeout_err, exp_te);
      chk({tag, "_res_data_hold"}, res_data, last_data);
      chk({tag, "_res_chan_hold"}, res_chan, last_chan);
      chk({tag, "_missing_events"}, trig_q.size() + res_q.size() + done_q.size(), 0);
   endtask

   // One complete scan. dly: -1 random 1..6, 0 never answer, >0 fixed delay.
   // Channel period from its launch edge b: trigger seen at b+s, result at
   // b+s+1+n, next channel launched at b+s+2+n.
   task automatic run_scan(input logic [NUM_CH-1:0] m, input int s, input int dly, input bit noise);
      int t, b, n, last, d;
      @(negedge PCLK);
      t = cyc + 1;
      b = t;
      last = t;
      exp_te = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (m[ch]) begin
            n = (dly < 0) ? $urandom_range(1, 6) : dly;
            d = (dq.size() != 0) ? dq.pop_front() : $urandom_range(0, 4095);
            plan_q.push_back('{n, d});
            trig_q.push_back('{b + s, ch, 0});
            last = b + s + 1 + ((n == 0) ? TMO : n);
            if (n != 0) begin
               res_q.push_back('{last, ch, d});
               last_data = d;
               last_chan = ch;
            end else begin
               exp_te = 1'b1;
            end
            b = last + 1;
         end
      end
      done_q.push_back('{last, 0, 0});
      busy_lo = t;
      busy_hi = (m != '0) ? last : t - 1;
      chan_mask = m;
      settle_cycles = 8'(s);
      start = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      chk("terr_cleared_on_start", timeout_err, 0);
      while (cyc <= last) begin
         if (noise && m != '0 && $urandom_range(0, 5) == 0) begin
            start = 1'b1;
            chan_mask = NUM_CH'($urandom);
            settle_cycles = 8'($urandom_range(0, 7));
         end else begin
            start = 1'b0;
         end
         @(negedge PCLK);
      end
      start = 1'b0;
      chk_idle_state("scan_end");
   endtask

   initial begin
      int t;
      repeat (3) @(negedge PCLK);
      chk_zero("reset");
      mon_en = 1'b1;
      PRESETn = 1'b1;

      // Two channels, settle 2, fixed data
      dq.push_back(12'h123);
      dq.push_back(12'h456);
      run_scan(8'h05, 2, 3, 1'b0);

      // Empty mask: only scan_done, never busy
      run_scan(8'h00, 3, -1, 1'b0);

      // Channel 7 never answers: timeout, then the next start clears it
      run_scan(8'h80, 1, 0, 1'b0);

      // Zero settle with mid-scan start pulses
      run_scan(8'h03, 0, -1, 1'b1);

      // Abort while waiting for a conversion; the late adc_done is ignored
      @(negedge PCLK);
      t = cyc + 1;
      busy_lo = t;
      busy_hi = 1 << 30;
      exp_te = 1'b0;
      trig_q.push_back('{t + 1, 0, 0});
      plan_q.push_back('{5, 12'hABC});
      chan_mask = 8'h01;
      settle_cycles = 8'd1;
      start = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      while (cyc < t + 3) @(negedge PCLK);
      abort = 1'b1;
      busy_hi = cyc;
      @(negedge PCLK);
      abort = 1'b0;
      repeat (10) @(negedge PCLK);
      chk_idle_state("abort_wait");

      // Abort and start together: nothing happens
      busy_lo = 1;
      busy_hi = 0;
      chan_mask = 8'h0F;
      settle_cycles = 8'd0;
      start = 1'b1;
      abort = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      abort = 1'b0;
      repeat (4) @(negedge PCLK);
      chk_idle_state("abort_start");

      // Reset during SETTLE of a full scan
      t = cyc + 1;
      busy_lo = t;
      busy_hi = 1 << 30;
      chan_mask = 8'hFF;
      settle_cycles = 8'd5;
      start = 1'b1;
      @(negedge PCLK);
      start = 1'b0;
      @(negedge PCLK);
      PRESETn = 1'b0;
      busy_hi = cyc;
      @(negedge PCLK);
      chk_zero("reset_mid_scan");
      PRESETn = 1'b1;
      last_data = 0;
      last_chan = 0;
      exp_te = 1'b0;
      run_scan(8'hFF, 1, -1, 1'b0);

      // Randomized scans
      for (int i = 0; i < 20; i++) begin
         run_scan(NUM_CH'($urandom_range(0, 255)), $urandom_range(0, 4), -1, 1'b1);
      end

      repeat (5) @(negedge PCLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of AMUX channels (power of 2, 2..16); CW = log2(NUM_CH).
REQ-002 SHALL have parameter RES_WIDTH, default 12, ADC sample width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles for adc_done (1..255).
REQ-004 SHALL have PCLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have PRESETn  input  1  reset; synchronous, active-low.
REQ-006 SHALL have start  input  1  one-cycle pulse, begin scan.
REQ-007 SHALL have abort  input  1  terminate scan.
REQ-008 SHALL have chan_mask  input  NUM_CH  enabled channels, bit i = channel i.
REQ-009 SHALL have settle_cycles  input  8  AMUX settling delay in cycles.
REQ-010 SHALL have amux_sel  output  CW  channel select to AMUX.
REQ-011 SHALL have adc_trigger  output  1  one-cycle conversion start.
REQ-012 SHALL have adc_done  input  1  one-cycle conversion complete.
REQ-013 SHALL have adc_data  input  RES_WIDTH  sample, valid only with adc_done.
REQ-014 SHALL have res_valid  output  1  one-cycle result strobe.
REQ-015 SHALL have res_chan  output  CW  channel of current result.
REQ-016 SHALL have res_data  output  RES_WIDTH  current result.
REQ-017 SHALL have busy  output  1  high in any state except IDLE.
REQ-018 SHALL have scan_done  output  1  one-cycle end-of-scan strobe.
REQ-019 SHALL have timeout_err  output  1  sticky conversion-timeout flag.

Function
REQ-020 SHALL implement states IDLE, SETTLE, TRIG, WAIT, NEXT.
REQ-021 IDLE: start (edge t) with chan_mask != 0 SHALL latch chan_mask and settle_cycles, clear timeout_err, drive amux_sel = lowest set bit from t+1; next state SETTLE, or TRIG if settle_cycles = 0.
REQ-022 IDLE: start with chan_mask = 0 SHALL pulse scan_done in cycle t+1, clear timeout_err, remain IDLE, never assert busy.
REQ-023 start while busy SHALL be ignored; chan_mask/settle_cycles changes mid-scan SHALL have no effect.
REQ-024 SETTLE SHALL last exactly the latched settle_cycles cycles, then TRIG.
REQ-025 TRIG SHALL assert adc_trigger for exactly one cycle, then WAIT; adc_trigger low in all other states.
REQ-026 WAIT: adc_done in WAIT cycle n (n = 1..TIMEOUT) SHALL register adc_data into res_data, current channel into res_chan, and enter NEXT with res_valid = 1 in that NEXT cycle.
REQ-027 WAIT: no adc_done after TIMEOUT cycles SHALL set timeout_err, leave res_* unchanged, no res_valid, enter NEXT.
REQ-028 adc_done outside WAIT SHALL be ignored.
REQ-029 NEXT (one cycle): clear current bit of latched mask; if remainder != 0, select lowest remaining bit on amux_sel and go SETTLE (or TRIG if settle = 0); else pulse scan_done in this NEXT cycle and go IDLE.
REQ-030 Channels SHALL be scanned in ascending index order, each once per scan.
REQ-031 abort SHALL force IDLE on the next edge from any state; no res_valid or scan_done for the aborted scan; abort beats start in the same cycle.
REQ-032 amux_sel, res_chan, res_data SHALL hold their last values in IDLE.
REQ-033 timeout_err SHALL clear only on accepted start or reset.

Reset
REQ-034 PRESETn = 0 at an edge SHALL set state IDLE and all outputs 0 (amux_sel, adc_trigger, res_*, busy, scan_done, timeout_err), including mid-scan, with no strobes emitted.

Verification
REQ-035 mask=0x05, settle=2, done 3 cycles after each trigger, data 0x123 then 0x456 -> trigger at t+3; res_valid (ch0,0x123) then (ch2,0x456); scan_done coincident with second res_valid; busy low next cycle.
REQ-036 mask=0x00 start -> scan_done at t+1 only; busy, adc_trigger never high.
REQ-037 mask=0x80, adc_done never -> amux_sel=7; after 255 WAIT cycles timeout_err=1, no res_valid, scan_done; next start clears timeout_err.
REQ-038 abort during WAIT, then adc_done -> busy 0 next cycle; no res_valid, no scan_done; res_data unchanged.
REQ-039 settle=0, mask=0x03 -> adc_trigger at t+1; start pulses mid-scan ignored; second trigger one cycle after first NEXT.
REQ-040 PRESETn low during SETTLE of scan mask=0xFF -> all outputs 0 next cycle; subsequent start scans from channel 0.
